// File: rtl/vi_pkg.sv
// Shared definitions for the integer-pipeline issue controller:
// register file geometry, controller states and the bubble instruction.
package vi_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/vi_scoreboard.sv
// Per-register pending-write scoreboard; x0 is never tracked.
module vi_scoreboard #(
    parameter int NUM_REGS = vi_pkg::NUM_REGS,
    parameter int ADDR_W   = vi_pkg::ADDR_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                wb_en,
    input  logic [ADDR_W-1:0]   wb_addr,
    input  logic                set_en,
    input  logic [ADDR_W-1:0]   set_addr,
    output logic [NUM_REGS-1:0] pend_eff,
    output logic                wb_was_pending
);

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] wb_mask;
    logic [NUM_REGS-1:0] set_mask;

    always_comb begin
        wb_mask  = '0;
        set_mask = '0;
        if (wb_en && wb_addr != '0)
            wb_mask[wb_addr] = 1'b1;
        if (set_en && set_addr != '0)
            set_mask[set_addr] = 1'b1;
    end

    // Writeback clears are visible to readers in the same cycle.
    assign pend_eff       = pending & ~wb_mask;
    assign wb_was_pending = pending[wb_addr];

    // Set is applied after clear so a same-cycle new owner keeps the bit.
    always_ff @(posedge clock) begin
        if (reset)
            pending <= '0;
        else
            pending <= pend_eff | set_mask;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Scoreboard-based issue controller: hazard/full detection, RUN/HOLD/DRAIN
// sequencing, in-flight write counting and sticky scoreboard error.
module pipe_hazard_ctrl import vi_pkg::*; #(
    parameter int NUM_REGS     = vi_pkg::NUM_REGS,
    parameter int ADDR_W       = vi_pkg::ADDR_W,
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              dec_valid,
    input  logic [ADDR_W-1:0] dec_read_addr_a,
    input  logic [ADDR_W-1:0] dec_read_addr_b,
    input  logic              dec_uses_a,
    input  logic              dec_uses_b,
    input  logic [ADDR_W-1:0] dec_write_addr,
    input  logic              dec_int_write_enable,
    input  logic              wb_int_write_enable,
    input  logic [ADDR_W-1:0] wb_write_addr,
    input  logic              drain_req,
    output logic              issue,
    output logic              stall,
    output logic              bubble,
    output logic [CNT_W-1:0]  inflight_count,
    output logic              drained,
    output logic              sb_error
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

    state_t              state;
    state_t              state_next;
    logic [NUM_REGS-1:0] pend_eff;
    logic                wb_was_pending;
    logic                wb_valid;
    logic                hazard;
    logic                full;
    logic                inc;
    logic [CNT_W-1:0]    count_next;

    assign wb_valid = wb_int_write_enable && (wb_write_addr != '0);

    vi_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clock          (clock),
        .reset          (reset),
        .wb_en          (wb_valid),
        .wb_addr        (wb_write_addr),
        .set_en         (inc),
        .set_addr       (dec_write_addr),
        .pend_eff       (pend_eff),
        .wb_was_pending (wb_was_pending)
    );

    assign hazard = (dec_uses_a && pend_eff[dec_read_addr_a])
                  | (dec_uses_b && pend_eff[dec_read_addr_b])
                  | (dec_int_write_enable && pend_eff[dec_write_addr]);
    assign full   = (inflight_count == MAX_CNT) && !wb_valid;

    assign issue  = (state != DRAIN) && dec_valid && !hazard && !full && !drain_req;
    assign stall  = dec_valid && !issue;
    assign bubble = !issue;
    assign inc    = issue && dec_int_write_enable && (dec_write_addr != '0);

    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (drain_req)
                    state_next = DRAIN;
                else if (dec_valid && (hazard || full))
                    state_next = HOLD;
            end
            HOLD: begin
                if (drain_req)
                    state_next = DRAIN;
                else if (issue)
                    state_next = RUN;
            end
            DRAIN: begin
                if (!drain_req)
                    state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    // Simultaneous issue and writeback cancel; decrement saturates at zero.
    always_comb begin
        count_next = inflight_count;
        if (inc && !wb_valid)
            count_next = inflight_count + 1'b1;
        else if (!inc && wb_valid && inflight_count != '0)
            count_next = inflight_count - 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= RUN;
            inflight_count <= '0;
            drained        <= 1'b0;
            sb_error       <= 1'b0;
        end else begin
            state          <= state_next;
            inflight_count <= count_next;
            drained        <= (state == DRAIN) && drain_req && (count_next == '0);
            if ((wb_valid && !wb_was_pending) ||
                (wb_valid && !inc && inflight_count == '0))
                sb_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vector table, hand-written
// drain/error/reset sequences and random traffic against a behavioural model.
module tb_pipe_hazard_ctrl;

    logic       clock;
    logic       reset;
    logic       dec_valid;
    logic [4:0] dec_read_addr_a;
    logic [4:0] dec_read_addr_b;
    logic       dec_uses_a;
    logic       dec_uses_b;
    logic [4:0] dec_write_addr;
    logic       dec_int_write_enable;
    logic       wb_int_write_enable;
    logic [4:0] wb_write_addr;
    logic       drain_req;
    logic       issue;
    logic       stall;
    logic       bubble;
    logic [2:0] inflight_count;
    logic       drained;
    logic       sb_error;

    pipe_hazard_ctrl #(
        .NUM_REGS     (32),
        .ADDR_W       (5),
        .MAX_INFLIGHT (4),
        .CNT_W        (3)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .dec_valid            (dec_valid),
        .dec_read_addr_a      (dec_read_addr_a),
        .dec_read_addr_b      (dec_read_addr_b),
        .dec_uses_a           (dec_uses_a),
        .dec_uses_b           (dec_uses_b),
        .dec_write_addr       (dec_write_addr),
        .dec_int_write_enable (dec_int_write_enable),
        .wb_int_write_enable  (wb_int_write_enable),
        .wb_write_addr        (wb_write_addr),
        .drain_req            (drain_req),
        .issue                (issue),
        .stall                (stall),
        .bubble               (bubble),
        .inflight_count       (inflight_count),
        .drained              (drained),
        .sb_error             (sb_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       v;
        logic [4:0] a;
        logic       ua;
        logic [4:0] b;
        logic       ub;
        logic [4:0] d;
        logic       we;
        logic       wbe;
        logic [4:0] wba;
        logic       drq;
        logic       e_issue;
        logic       e_stall;
        logic [2:0] e_cnt;
        logic       e_drained;
        logic       e_err;
    } vec_t;

    int pass_cnt = 0;
    int total_cnt = 0;

    // behavioural model state
    bit m_pend [32];
    int m_cnt;
    bit m_drain;
    bit m_err;
    bit m_drained;

    function automatic vec_t mk(input logic v, input logic [4:0] a, input logic ua,
                                input logic [4:0] b, input logic ub, input logic [4:0] d,
                                input logic we, input logic wbe, input logic [4:0] wba,
                                input logic drq, input logic e_issue, input logic e_stall,
                                input logic [2:0] e_cnt, input logic e_drained,
                                input logic e_err);
        vec_t t;
        t.v = v; t.a = a; t.ua = ua; t.b = b; t.ub = ub; t.d = d; t.we = we;
        t.wbe = wbe; t.wba = wba; t.drq = drq; t.e_issue = e_issue;
        t.e_stall = e_stall; t.e_cnt = e_cnt; t.e_drained = e_drained; t.e_err = e_err;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic drive(input vec_t t);
        dec_valid            = t.v;
        dec_read_addr_a      = t.a;
        dec_uses_a           = t.ua;
        dec_read_addr_b      = t.b;
        dec_uses_b           = t.ub;
        dec_write_addr       = t.d;
        dec_int_write_enable = t.we;
        wb_int_write_enable  = t.wbe;
        wb_write_addr        = t.wba;
        drain_req            = t.drq;
    endtask

    task automatic apply(input string tag, input vec_t t);
        drive(t);
        #4;
        chk({tag, ".issue"},   32'(issue),          32'(t.e_issue));
        chk({tag, ".stall"},   32'(stall),          32'(t.e_stall));
        chk({tag, ".bubble"},  32'(bubble),         32'(!t.e_issue));
        chk({tag, ".count"},   32'(inflight_count), 32'(t.e_cnt));
        chk({tag, ".drained"}, 32'(drained),        32'(t.e_drained));
        chk({tag, ".sb_error"},32'(sb_error),       32'(t.e_err));
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0));
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_cnt = 0;
        m_drain = 1'b0;
        m_err = 1'b0;
        m_drained = 1'b0;
    endtask

    vec_t tbl[$];

    initial begin
        reset = 1'b1;
        drive(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0));
        @(posedge clock);
        #1;
        // still in reset: idle registered outputs, issue follows dec_valid
        apply("reset", mk(1,0,0,0,0,1,1,0,0,0, 1,0,0,0,0));
        reset = 1'b0;

        //        v  a ua b ub d we wbe wba drq  iss stl cnt dr err
        // back-to-back independent writes
        tbl.push_back(mk(1, 0,0, 0,0, 1,1, 0,0, 0,  1,0,0,0,0));
        tbl.push_back(mk(1, 0,0, 0,0, 2,1, 0,0, 0,  1,0,1,0,0));
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0,0, 0,  0,0,2,0,0));
        // RAW on x1, released by the x1 writeback in the same cycle
        tbl.push_back(mk(1, 1,1, 0,0, 3,1, 0,0, 0,  0,1,2,0,0));
        tbl.push_back(mk(1, 1,1, 0,0, 3,1, 0,0, 0,  0,1,2,0,0));
        tbl.push_back(mk(1, 1,1, 0,0, 3,1, 1,1, 0,  1,0,2,0,0));
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 1,2, 0,  0,0,2,0,0));
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 1,3, 0,  0,0,1,0,0));
        // WAW on x5; same-cycle wb+issue keeps x5 pending
        tbl.push_back(mk(1, 0,0, 0,0, 5,1, 0,0, 0,  1,0,0,0,0));
        tbl.push_back(mk(1, 0,0, 0,0, 5,1, 0,0, 0,  0,1,1,0,0));
        tbl.push_back(mk(1, 0,0, 0,0, 5,1, 1,5, 0,  1,0,1,0,0));
        tbl.push_back(mk(1, 5,1, 0,0, 6,0, 0,0, 0,  0,1,1,0,0));
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 1,5, 0,  0,0,1,0,0));
        // fill to MAX_INFLIGHT, fifth blocked, then let through by a writeback
        tbl.push_back(mk(1, 0,0, 0,0, 1,1, 0,0, 0,  1,0,0,0,0));
        tbl.push_back(mk(1, 0,0, 0,0, 2,1, 0,0, 0,  1,0,1,0,0));
        tbl.push_back(mk(1, 0,0, 0,0, 3,1, 0,0, 0,  1,0,2,0,0));
        tbl.push_back(mk(1, 0,0, 0,0, 4,1, 0,0, 0,  1,0,3,0,0));
        tbl.push_back(mk(1, 0,0, 0,0, 8,1, 0,0, 0,  0,1,4,0,0));
        tbl.push_back(mk(1, 0,0, 0,0, 8,1, 1,1, 0,  1,0,4,0,0));
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 1,2, 0,  0,0,4,0,0));
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 1,3, 0,  0,0,3,0,0));
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 1,4, 0,  0,0,2,0,0));
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 1,8, 0,  0,0,1,0,0));
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0,0, 0,  0,0,0,0,0));
        // x0 writes are neither tracked nor counted
        tbl.push_back(mk(1, 0,1, 0,0, 0,1, 0,0, 0,  1,0,0,0,0));
        tbl.push_back(mk(1, 0,1, 0,0, 0,1, 0,0, 0,  1,0,0,0,0));
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0,0, 0,  0,0,0,0,0));
        // unused source fields never hazard; source B does
        tbl.push_back(mk(1, 0,0, 0,0, 9,1, 0,0, 0,  1,0,0,0,0));
        tbl.push_back(mk(1, 9,0, 9,0,10,0, 0,0, 0,  1,0,1,0,0));
        tbl.push_back(mk(1, 0,0, 9,1,10,0, 0,0, 0,  0,1,1,0,0));
        tbl.push_back(mk(1, 0,0, 9,1,10,0, 1,9, 0,  1,0,1,0,0));
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0,0, 0,  0,0,0,0,0));

        foreach (tbl[i])
            apply($sformatf("tbl%0d", i), tbl[i]);

        // drain with two writes in flight
        do_reset();
        apply("drn0", mk(1, 0,0, 0,0, 1,1, 0,0, 0,  1,0,0,0,0));
        apply("drn1", mk(1, 0,0, 0,0, 2,1, 0,0, 0,  1,0,1,0,0));
        apply("drn2", mk(1, 0,0, 0,0, 3,1, 0,0, 1,  0,1,2,0,0));
        apply("drn3", mk(0, 0,0, 0,0, 0,0, 1,1, 1,  0,0,2,0,0));
        apply("drn4", mk(0, 0,0, 0,0, 0,0, 1,2, 1,  0,0,1,0,0));
        apply("drn5", mk(1, 0,0, 0,0, 3,1, 0,0, 1,  0,1,0,1,0));
        apply("drn6", mk(1, 0,0, 0,0, 3,1, 0,0, 0,  0,1,0,1,0));
        apply("drn7", mk(1, 0,0, 0,0, 3,1, 0,0, 0,  1,0,0,0,0));
        apply("drn8", mk(0, 0,0, 0,0, 0,0, 1,3, 0,  0,0,1,0,0));

        // stray writeback, sticky error, reset while held on a hazard
        do_reset();
        apply("err0", mk(1, 0,0, 0,0, 1,1, 0,0, 0,  1,0,0,0,0));
        apply("err1", mk(0, 0,0, 0,0, 0,0, 1,7, 0,  0,0,1,0,0));
        apply("err2", mk(0, 0,0, 0,0, 0,0, 0,0, 0,  0,0,0,0,1));
        apply("err3", mk(1, 1,1, 0,0, 2,1, 0,0, 0,  0,1,0,0,1));
        reset = 1'b1;
        apply("err4", mk(1, 1,1, 0,0, 2,1, 0,0, 0,  0,1,0,0,1));
        reset = 1'b0;
        apply("rst0", mk(1, 1,1, 0,0, 2,1, 0,0, 0,  1,0,0,0,0));
        apply("rst1", mk(0, 0,0, 0,0, 0,0, 1,2, 0,  0,0,1,0,0));
        apply("rst2", mk(0, 0,0, 0,0, 0,0, 1,2, 0,  0,0,0,0,0));
        apply("rst3", mk(0, 0,0, 0,0, 0,0, 0,0, 0,  0,0,0,0,1));

        // random traffic against the behavioural model
        do_reset();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            int q[$];
            int r;
            bit wbv, iss, haz, full, inc;
            bit pe [32];
            int nc;

            if ($urandom_range(0, 299) == 0) begin
                do_reset();
                model_reset();
            end

            dec_valid            = ($urandom_range(0, 9) < 7);
            dec_read_addr_a      = 5'($urandom_range(0, 7));
            dec_read_addr_b      = 5'($urandom_range(0, 7));
            dec_uses_a           = 1'($urandom_range(0, 1));
            dec_uses_b           = 1'($urandom_range(0, 1));
            dec_write_addr       = 5'($urandom_range(0, 7));
            dec_int_write_enable = ($urandom_range(0, 3) != 0);
            for (int k = 1; k < 32; k++)
                if (m_pend[k]) q.push_back(k);
            r = int'($urandom_range(0, 99));
            if (r < 40 && q.size() > 0) begin
                wb_int_write_enable = 1'b1;
                wb_write_addr       = 5'(q[$urandom_range(0, q.size() - 1)]);
            end else if (r < 42) begin
                wb_int_write_enable = 1'b1;
                wb_write_addr       = 5'($urandom_range(1, 7));
            end else if (r < 44) begin
                wb_int_write_enable = 1'b1;
                wb_write_addr       = 5'd0;
            end else begin
                wb_int_write_enable = 1'b0;
                wb_write_addr       = 5'($urandom_range(0, 7));
            end
            if (drain_req)
                drain_req = ($urandom_range(0, 5) != 0);
            else
                drain_req = ($urandom_range(0, 39) == 0);

            wbv = wb_int_write_enable && (wb_write_addr != 5'd0);
            foreach (pe[k])
                pe[k] = m_pend[k] && !(wbv && int'(wb_write_addr) == k);
            haz  = (dec_uses_a && pe[int'(dec_read_addr_a)])
                || (dec_uses_b && pe[int'(dec_read_addr_b)])
                || (dec_int_write_enable && pe[int'(dec_write_addr)]);
            full = (m_cnt == 4) && !wbv;
            iss  = dec_valid && !drain_req && !m_drain && !haz && !full;

            #4;
            chk("rnd.issue",    32'(issue),          32'(iss));
            chk("rnd.stall",    32'(stall),          32'(dec_valid && !iss));
            chk("rnd.bubble",   32'(bubble),         32'(!iss));
            chk("rnd.count",    32'(inflight_count), 32'(m_cnt));
            chk("rnd.drained",  32'(drained),        32'(m_drained));
            chk("rnd.sb_error", 32'(sb_error),       32'(m_err));

            inc = iss && dec_int_write_enable && (dec_write_addr != 5'd0);
            if (wbv && !m_pend[int'(wb_write_addr)]) m_err = 1'b1;
            if (wbv && !inc && m_cnt == 0) m_err = 1'b1;
            nc = m_cnt + int'(inc) - int'(wbv);
            if (nc < 0) nc = 0;
            if (wbv) m_pend[int'(wb_write_addr)] = 1'b0;
            if (inc) m_pend[int'(dec_write_addr)] = 1'b1;
            m_drained = m_drain && drain_req && (nc == 0);
            m_drain   = drain_req;
            m_cnt     = nc;

            @(posedge clock);
            #1;
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
